// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard / forwarding unit.
//
// Holds the EX-operand select encodings, the pipeline-tracker entry type,
// and a helper that tests whether a tracker entry produces a given register.
//
// Contents:
//   fwd_sel_e       : 2-bit operand select (regfile / MEM result / WB result)
//   MAX_REG_W       : storage width of a register index inside a tracker entry
//   MC_CNT_W        : width of the multi-cycle busy counter
//   trk_entry_t     : {valid, dst, wr_en, is_load} for one pipeline stage
//   TRK_BUBBLE      : an empty (invalid) tracker entry
//   tracker_hit()   : entry is valid, writes, and targets the given register
package hazard_forward_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2,
        FWD_RSVD = 2'd3
    } fwd_sel_e;

    // Register indices are zero-extended to this width inside the tracker so
    // the entry type does not depend on the NUM_REGS parameter.
    localparam int MAX_REG_W = 8;

    // Enough for the largest legal multi-cycle latency (15).
    localparam int MC_CNT_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [MAX_REG_W-1:0] dst;
        logic                 wr_en;
        logic                 is_load;
    } trk_entry_t;

    localparam trk_entry_t TRK_BUBBLE = '{
        valid:   1'b0,
        dst:     '0,
        wr_en:   1'b0,
        is_load: 1'b0
    };

    function automatic logic tracker_hit(input trk_entry_t e,
                                         input logic [MAX_REG_W-1:0] r);
        return e.valid && e.wr_en && (e.dst == r);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_mc_busy_counter.sv
// Busy counter for the multi-cycle (mul/div) unit.
//
// A start pulse loads LAT-1; the count then decrements once per cycle and
// busy is high while the count is non-zero, so busy covers the LAT-1 cycles
// that follow the issuing cycle.
//
// Ports:
//   clk    in  1  rising-edge clock
//   reset  in  1  synchronous active-high reset; abandons any operation
//   start  in  1  a multi-cycle op leaves ID this cycle
//   busy   out 1  multi-cycle unit occupied
//
// LAT must lie in 2..15.
module mc_busy_counter
    import hazard_forward_unit_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam logic [MC_CNT_W-1:0] LOAD_VAL = MC_CNT_W'(LAT - 1);

    logic [MC_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding control for an in-order pipeline.
//
// Tracks the instructions in EX, MEM and WB, raises a one-cycle stall for a
// load-use dependency, holds ID while the multi-cycle unit is busy, and
// registers per-port EX operand selects as an instruction moves ID -> EX.
//
// Ports:
//   clk           in  1               rising-edge clock
//   reset         in  1               synchronous active-high reset
//   id_valid      in  1               ID-stage instruction valid
//   id_src        in  NUM_SRC*REG_W   source indices, slice s is port s
//   id_src_used   in  NUM_SRC         port s is actually read
//   id_dst        in  REG_W           destination register
//   id_wr_en      in  1               instruction writes a register
//   id_is_load    in  1               instruction is a load
//   id_is_mc      in  1               instruction is a multi-cycle op
//   flush         in  1               kill the ID instruction
//   stall         out 1               hold PC and IF/ID, bubble into EX
//   fwd_sel       out NUM_SRC*2       registered EX select per port (fwd_sel_e)
//   mc_busy       out 1               multi-cycle unit occupied
//   id_is_branch  in  1               (FWD_BRANCH_EN only) ID is a branch
//   br_fwd        out NUM_SRC         (FWD_BRANCH_EN only) ID-stage MEM bypass
//
// Configuration macro: FWD_BRANCH_EN adds ID-stage branch operand bypass.
//
// Handshake: there is no valid/ready pair here; an ID instruction moves to
// EX on the rising edge exactly when id_valid & !stall & !flush, otherwise
// EX receives a bubble. flush always overrides stall.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int NUM_SRC  = 2,
    parameter int MC_LAT   = 4,
    parameter int REG_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
    input  logic [REG_W-1:0]         id_dst,
    input  logic                     id_wr_en,
    input  logic                     id_is_load,
    input  logic                     id_is_mc,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*2-1:0]     fwd_sel,
    output logic                     mc_busy
`ifdef FWD_BRANCH_EN
    ,
    input  logic                     id_is_branch,
    output logic [NUM_SRC-1:0]       br_fwd
`endif
);

    // Pipeline tracker
    trk_entry_t trk_ex;
    trk_entry_t trk_mem;
    trk_entry_t trk_wb;
    trk_entry_t id_entry;

    logic [MAX_REG_W-1:0] src_ext [NUM_SRC];
    logic [NUM_SRC*2-1:0] fwd_next;
    logic                 load_use;
    logic                 branch_haz;
    logic                 accept;
    logic                 mc_start;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            src_ext[s] = MAX_REG_W'(id_src[s*REG_W +: REG_W]);
        end
    end

    always_comb begin
        id_entry         = TRK_BUBBLE;
        id_entry.valid   = 1'b1;
        id_entry.dst     = MAX_REG_W'(id_dst);
        id_entry.wr_en   = id_wr_en;
        id_entry.is_load = id_is_load;
    end

    // Load in EX whose result a used ID source needs: the data only exists
    // after MEM, so the consumer has to wait one cycle and then picks it up
    // from WB.
    always_comb begin
        load_use = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_src_used[s] && trk_ex.is_load && tracker_hit(trk_ex, src_ext[s])) begin
                load_use = 1'b1;
            end
        end
    end

`ifdef FWD_BRANCH_EN
    // Branches resolve in ID, so they can only bypass from MEM. A producer
    // still in EX, or a load still in MEM, is not ready yet.
    always_comb begin
        branch_haz = 1'b0;
        br_fwd     = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_is_branch && id_src_used[s] && (src_ext[s] != '0)) begin
                if (tracker_hit(trk_ex, src_ext[s]) ||
                    (trk_mem.is_load && tracker_hit(trk_mem, src_ext[s]))) begin
                    branch_haz = 1'b1;
                end
                if (id_valid && !trk_mem.is_load && tracker_hit(trk_mem, src_ext[s])) begin
                    br_fwd[s] = 1'b1;
                end
            end
        end
    end
`else
    assign branch_haz = 1'b0;
`endif

    assign stall    = id_valid && !flush && (load_use || mc_busy || branch_haz);
    assign accept   = id_valid && !stall && !flush;
    assign mc_start = accept && id_is_mc;

    // Selects for the instruction about to enter EX: what is in EX now will
    // be in MEM, what is in MEM now will be in WB. Youngest producer wins.
    always_comb begin
        fwd_next = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_src_used[s] && (src_ext[s] != '0)) begin
                if (tracker_hit(trk_ex, src_ext[s])) begin
                    fwd_next[2*s +: 2] = FWD_MEM;
                end else if (tracker_hit(trk_mem, src_ext[s])) begin
                    fwd_next[2*s +: 2] = FWD_WB;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trk_ex  <= TRK_BUBBLE;
            trk_mem <= TRK_BUBBLE;
            trk_wb  <= TRK_BUBBLE;
            fwd_sel <= '0;
        end else begin
            trk_ex  <= accept ? id_entry : TRK_BUBBLE;
            trk_mem <= trk_ex;
            trk_wb  <= trk_mem;
            fwd_sel <= accept ? fwd_next : '0;
        end
    end

    // WB is tracked so the stage contents stay observable for the regfile
    // write side; no hazard decision here depends on it.
    logic wb_unused;
    assign wb_unused = ^{trk_wb, trk_mem.is_load};

    mc_busy_counter #(
        .LAT (MC_LAT)
    ) u_mc_busy_counter (
        .clk   (clk),
        .reset (reset),
        .start (mc_start),
        .busy  (mc_busy)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int NUM_REGS = 16;
  localparam int NUM_SRC  = 2;
  localparam int MC_LAT   = 4;
  localparam int REG_W    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [REG_W-1:0]         id_dst;
  logic                     id_wr_en;
  logic                     id_is_load;
  logic                     id_is_mc;
  logic                     flush;
  logic                     stall;
  logic [NUM_SRC*2-1:0]     fwd_sel;
  logic                     mc_busy;
`ifdef FWD_BRANCH_EN
  logic                     id_is_branch;
  logic [NUM_SRC-1:0]       br_fwd;
`endif

  hazard_forward_unit #(
    .NUM_REGS (NUM_REGS),
    .NUM_SRC  (NUM_SRC),
    .MC_LAT   (MC_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_dst       (id_dst),
    .id_wr_en     (id_wr_en),
    .id_is_load   (id_is_load),
    .id_is_mc     (id_is_mc),
    .flush        (flush),
    .stall        (stall),
    .fwd_sel      (fwd_sel),
    .mc_busy      (mc_busy)
`ifdef FWD_BRANCH_EN
    ,
    .id_is_branch (id_is_branch),
    .br_fwd       (br_fwd)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] used,
                       input int dst, input bit wr, input bit ld, input bit mc, input bit fl);
    logic [REG_W-1:0] a;
    logic [REG_W-1:0] b;
    a = REG_W'(s0);
    b = REG_W'(s1);
    id_valid    = v;
    id_src      = {b, a};
    id_src_used = used;
    id_dst      = REG_W'(dst);
    id_wr_en    = wr;
    id_is_load  = ld;
    id_is_mc    = mc;
    flush       = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string    name;
    bit       v;
    int       s0;
    int       s1;
    bit [1:0] used;
    int       dst;
    bit       wr;
    bit       ld;
    bit       mc;
    bit       fl;
    bit       exp_stall;
    bit [3:0] exp_fwd;
    bit       exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input bit v, input int s0, input int s1,
                         input bit [1:0] used, input int dst, input bit wr, input bit ld,
                         input bit mc, input bit fl, input bit es, input bit [3:0] ef,
                         input bit eb);
    vec_t t;
    t.name = name; t.v = v; t.s0 = s0; t.s1 = s1; t.used = used; t.dst = dst;
    t.wr = wr; t.ld = ld; t.mc = mc; t.fl = fl;
    t.exp_stall = es; t.exp_fwd = ef; t.exp_busy = eb;
    vecs.push_back(t);
  endtask

  // ---------------- reference model ----------------
  // Pipeline contents by age: element 0 entered EX most recently.
  typedef struct {
    bit v;
    int dst;
    bit wr;
    bit ld;
  } minstr_t;

  function automatic bit m_writes(input minstr_t e, input int r);
    return e.v && e.wr && (e.dst == r);
  endfunction

  function automatic logic [1:0] model_sel(input bit used, input int src,
                                           input minstr_t ex, input minstr_t mem);
    if (!used || src == 0) return 2'd0;
    if (m_writes(ex, src)) return 2'd1;
    if (m_writes(mem, src)) return 2'd2;
    return 2'd0;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    minstr_t pipe[$];
    minstr_t ex_i;
    minstr_t mem_i;
    minstr_t bub;
    minstr_t nw;
    int       cyc;
    int       mc_end;
    bit [3:0] exp_fwd;

    reset = 1'b1;
`ifdef FWD_BRANCH_EN
    id_is_branch = 1'b0;
`endif
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_fwd", 32'(fwd_sel), 32'd0);
    check("reset_busy", 32'(mc_busy), 32'd0);
    next_cycle();

    //      name          v  s0 s1 used  dst wr ld mc fl stall fwd      busy
    add_vec("r3_prod",    1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("r3_cons",    1, 3, 0, 2'b01, 4, 1, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("r3_in_ex",   0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0001, 0);
    add_vec("ld_r5",      1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 4'b0000, 0);
    add_vec("use_r5_st",  1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 1, 4'b0000, 0);
    add_vec("use_r5_go",  1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("r5_from_wb", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b1010, 0);
    add_vec("w3a",        1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("w3b",        1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("r3_both",    1, 3, 3, 2'b11, 7, 1, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("r3_both_ex", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0101, 0);
    add_vec("ld_r7",      1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0, 4'b0000, 0);
    add_vec("lu_flush",   1, 7, 0, 2'b01, 8, 1, 0, 0, 1, 0, 4'b0000, 0);
    add_vec("flush_bub",  0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("w0",         1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("r0_src",     1, 0, 0, 2'b11, 9, 1, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("r0_in_ex",   0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("mc_op",      1, 0, 0, 2'b00, 9, 1, 0, 1, 0, 0, 4'b0000, 0);
    add_vec("add_wait1",  1, 1, 0, 2'b01, 2, 1, 0, 0, 0, 1, 4'b0000, 1);
    add_vec("add_wait2",  1, 1, 0, 2'b01, 2, 1, 0, 0, 0, 1, 4'b0000, 1);
    add_vec("add_wait3",  1, 1, 0, 2'b01, 2, 1, 0, 0, 0, 1, 4'b0000, 1);
    add_vec("add_go",     1, 1, 0, 2'b01, 2, 1, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("idle",       0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    add_vec("mc2",        1, 0, 0, 2'b00, 10, 1, 0, 1, 0, 0, 4'b0000, 0);
    add_vec("mc2_b3",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    add_vec("mc2_b2",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    add_vec("mc_at1",     1, 0, 0, 2'b00, 11, 1, 0, 1, 0, 1, 4'b0000, 1);
    add_vec("mc_restart", 1, 0, 0, 2'b00, 11, 1, 0, 1, 0, 0, 4'b0000, 0);
    add_vec("mc3_b3",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    add_vec("mc3_b2",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    add_vec("mc3_b1",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    add_vec("mc3_done",   0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].s0, vecs[i].s1, vecs[i].used, vecs[i].dst,
            vecs[i].wr, vecs[i].ld, vecs[i].mc, vecs[i].fl);
      @(negedge clk);
      check({vecs[i].name, "_stall"}, 32'(stall), 32'(vecs[i].exp_stall));
      check({vecs[i].name, "_fwd"}, 32'(fwd_sel), 32'(vecs[i].exp_fwd));
      check({vecs[i].name, "_busy"}, 32'(mc_busy), 32'(vecs[i].exp_busy));
      next_cycle();
    end

    // Reset in the middle of a multi-cycle op, with a load-use pair pending
    drive(1, 0, 0, 2'b00, 12, 1, 1, 1, 0);
    @(negedge clk);
    check("rmc_issue_stall", 32'(stall), 32'd0);
    next_cycle();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rmc_busy_before", 32'(mc_busy), 32'd1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(1, 12, 0, 2'b01, 13, 1, 0, 0, 0);
    @(negedge clk);
    check("rmc_busy_after", 32'(mc_busy), 32'd0);
    check("rmc_stall_after", 32'(stall), 32'd0);
    check("rmc_fwd_after", 32'(fwd_sel), 32'd0);
    next_cycle();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rmc_no_fwd", 32'(fwd_sel), 32'd0);
    next_cycle();

    // ---------------- randomized run against the model ----------------
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bub = '{v: 1'b0, dst: 0, wr: 1'b0, ld: 1'b0};
    pipe.delete();
    repeat (3) pipe.push_back(bub);
    cyc = 0;
    mc_end = 0;
    exp_fwd = '0;

    for (int n = 0; n < 3000; n++) begin
      bit v, wr, ld, mc, fl, rs, busy, lu, st, acc;
      bit [1:0] used;
      int s0, s1, dst;
      bit [3:0] sel;

      v    = ($urandom_range(0, 3) != 0);
      s0   = $urandom_range(0, 7);
      s1   = $urandom_range(0, 7);
      used = 2'($urandom_range(0, 3));
      dst  = $urandom_range(0, 7);
      wr   = ($urandom_range(0, 3) != 0);
      ld   = ($urandom_range(0, 3) == 0);
      mc   = ($urandom_range(0, 11) == 0);
      fl   = ($urandom_range(0, 7) == 0);
      rs   = ($urandom_range(0, 199) == 0);
      drive(v, s0, s1, used, dst, wr, ld, mc, fl);
      reset = rs;

      ex_i  = pipe[0];
      mem_i = pipe[1];
      busy  = (cyc < mc_end);
      lu    = ex_i.ld && ((used[0] && m_writes(ex_i, s0)) || (used[1] && m_writes(ex_i, s1)));
      st    = v && !fl && (busy || lu);
      acc   = v && !st && !fl;
      sel   = {model_sel(used[1], s1, ex_i, mem_i), model_sel(used[0], s0, ex_i, mem_i)};

      @(negedge clk);
      check("rnd_stall", 32'(stall), 32'(st));
      check("rnd_busy", 32'(mc_busy), 32'(busy));
      check("rnd_fwd", 32'(fwd_sel), 32'(exp_fwd));
      next_cycle();

      if (rs) begin
        pipe.delete();
        repeat (3) pipe.push_back(bub);
        mc_end = 0;
        exp_fwd = '0;
        cyc = 0;
      end else begin
        nw = acc ? '{v: 1'b1, dst: dst, wr: wr, ld: ld} : bub;
        pipe.push_front(nw);
        void'(pipe.pop_back());
        exp_fwd = acc ? sel : 4'b0000;
        if (acc && mc) mc_end = cyc + MC_LAT;
        cyc++;
      end
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
